// File: rtl/pagerank_convergence_ctrl.sv
// PageRank convergence controller: captures final-stage ranks, streams them out, decides stop/continue.
// Optional PR_LOCAL_DELTA_EN: derive delta from successive rank vectors instead of the delta input.
module pagerank_convergence_ctrl #(
    parameter int NUM_HW_THREADS = 8,
    parameter int NODES_IN_GRAPH = 32,
    localparam int IDX_W = $clog2(NODES_IN_GRAPH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [63:0]      i_threshold,
    input  logic [15:0]      i_max_iter,
    input  logic [63:0]      i_pagerank_final [NODES_IN_GRAPH],
    input  logic [63:0]      i_delta,
    input  logic             i_pagerank_iteration_complete,
    output logic             o_iter_start,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [IDX_W-1:0] o_wb_node_id,
    output logic [63:0]      o_wb_data,
    output logic [15:0]      o_iter_count,
    output logic [63:0]      o_delta_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_converged
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ITER,
        S_WRITEBACK,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_cmp_q;
    logic [63:0]      r_snap [NODES_IN_GRAPH];
    logic [IDX_W-1:0] r_idx;
    logic             r_iter_start;
    logic             r_busy;
    logic             r_done;
    logic             r_conv;
    logic [15:0]      r_iter_count;
    logic [63:0]      r_delta_out;

    logic             w_cmp_rise;
    logic             w_run_start;
    logic             w_capture;
    logic             w_wb_valid;
    logic             w_xfer;
    logic             w_last;
    logic [63:0]      w_d_used;
    logic [15:0]      w_iter_lim;
    logic [16:0]      w_iter_nxt;
    logic             w_conv_now;
    logic             w_stop;

    assign w_cmp_rise = i_pagerank_iteration_complete & ~r_cmp_q;
    assign w_xfer     = w_wb_valid & i_wb_ready;
    assign w_last     = w_xfer & (r_idx == IDX_W'(NODES_IN_GRAPH - 1));
    assign w_iter_lim = (i_max_iter == 16'd0) ? 16'd1 : i_max_iter;
    assign w_iter_nxt = {1'b0, r_iter_count} + 17'd1;
    assign w_conv_now = w_d_used < i_threshold;
    assign w_stop     = w_conv_now | (w_iter_nxt >= {1'b0, w_iter_lim});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_run_start = 1'b0;
        w_capture   = 1'b0;
        w_wb_valid  = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_run_start = 1'b1;
                    w_next      = S_WAIT_ITER;
                end
            end
            S_WAIT_ITER: begin
                if (w_cmp_rise) begin
                    w_capture = 1'b1;
                    w_next    = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                w_wb_valid = 1'b1;
                if (w_last) begin
                    w_next = S_DECIDE;
                end
            end
            S_DECIDE: begin
                w_next = w_stop ? S_DONE : S_WAIT_ITER;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_q      <= 1'b0;
            r_idx        <= '0;
            r_iter_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_conv       <= 1'b0;
            r_iter_count <= 16'd0;
            r_delta_out  <= 64'd0;
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                r_snap[i] <= 64'd0;
            end
        end else begin
            r_cmp_q      <= i_pagerank_iteration_complete;
            r_iter_start <= 1'b0;
            if (w_run_start) begin
                r_iter_count <= 16'd0;
                r_done       <= 1'b0;
                r_conv       <= 1'b0;
                r_busy       <= 1'b1;
                r_iter_start <= 1'b1;
                r_idx        <= '0;
            end
            if (w_capture) begin
                for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                    r_snap[i] <= i_pagerank_final[i];
                end
            end
            if (w_xfer) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            // Saturate rather than wrap so a long run never looks freshly started
            if (r_state == S_DECIDE) begin
                r_iter_count <= w_iter_nxt[16] ? 16'hFFFF : w_iter_nxt[15:0];
                r_delta_out  <= w_d_used;
                if (w_stop) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_conv <= w_conv_now;
                end else begin
                    r_iter_start <= 1'b1;
                end
            end
        end
    end

`ifdef PR_LOCAL_DELTA_EN
    logic [63:0] r_prev [NODES_IN_GRAPH];
    logic [63:0] r_acc;
    logic [63:0] w_cur;
    logic [63:0] w_old;
    logic [63:0] w_diff;
    logic [64:0] w_sum;

    assign w_cur  = r_snap[r_idx];
    assign w_old  = r_prev[r_idx];
    assign w_diff = (w_cur >= w_old) ? (w_cur - w_old) : (w_old - w_cur);
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_diff};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= 64'd0;
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                r_prev[i] <= 64'd0;
            end
        end else begin
            if (w_run_start) begin
                for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                    r_prev[i] <= 64'd0;
                end
            end else if (w_xfer) begin
                r_prev[r_idx] <= w_cur;
            end
            if (w_capture) begin
                r_acc <= 64'd0;
            end else if (w_xfer) begin
                r_acc <= w_sum[64] ? '1 : w_sum[63:0];
            end
        end
    end

    assign w_d_used = r_acc;
`else
    logic [63:0] r_delta_snap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_delta_snap <= 64'd0;
        end else if (w_capture) begin
            r_delta_snap <= i_delta;
        end
    end

    assign w_d_used = r_delta_snap;
`endif

    assign o_iter_start = r_iter_start;
    assign o_wb_valid   = w_wb_valid;
    assign o_wb_node_id = r_idx;
    assign o_wb_data    = r_snap[r_idx];
    assign o_iter_count = r_iter_count;
    assign o_delta_out  = r_delta_out;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_converged  = r_conv;

endmodule
